// File: rtl/isa_pkg.sv
// isa_pkg: shared run-control state encoding and program-counter defaults
package isa_pkg;

   typedef enum logic [1:0] {IDLE, RUN, HALTED} pc_state_t;

   localparam int PC_W          = 9;
   localparam int PC_START_ADDR = 0;

endpackage

// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter and IDLE/RUN/HALTED run control with a saturating RUN-cycle counter
module pc_sequencer
   import isa_pkg::*;
#(
   parameter int D          = PC_W,
   parameter int START_ADDR = PC_START_ADDR,
   parameter int CW         = 16
) (
   input  logic          Clk,
   input  logic          Reset_n,
   input  logic          start,
   input  logic          stall,
   input  logic          halt,
   input  logic [D-1:0]  target,
   output logic [D-1:0]  prog_addr,
   output logic          running,
   output logic          done,
   output logic [CW-1:0] cycle_cnt
);

   pc_state_t     state_q, state_d;
   logic [D-1:0]  pc_q, pc_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // next state: start (re)launches from IDLE/HALTED; in RUN halt beats stall beats advance
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      cnt_d   = cnt_q;
      case (state_q)
         RUN: begin
            cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);
            if (halt)
               state_d = HALTED;
            else if (!stall)
               pc_d = target;
         end
         default: begin
            if (start) begin
               state_d = RUN;
               pc_d    = D'(START_ADDR);
               cnt_d   = '0;
            end
         end
      endcase
   end

   // state, PC and counter registers; reset aborts any run immediately
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= IDLE;
         pc_q    <= D'(START_ADDR);
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         cnt_q   <= cnt_d;
      end
   end

   assign prog_addr = pc_q;
   assign running   = (state_q == RUN);
   assign done      = (state_q == HALTED);
   assign cycle_cnt = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: table-driven checks of pc_sequencer plus async-reset and saturation sequences
module tb_pc_sequencer;

   localparam int CW = 6;

   typedef struct {
      logic       start;
      logic       stall;
      logic       halt;
      logic [8:0] target;
      logic [8:0] pc;
      logic       run;
      logic       done;
      int         cnt;
   } vec_t;

   logic          Clk = 1'b0;
   logic          Reset_n = 1'b0;
   logic          start = 1'b0;
   logic          stall = 1'b0;
   logic          halt = 1'b0;
   logic [8:0]    target = '0;
   logic [8:0]    prog_addr;
   logic          running;
   logic          done;
   logic [CW-1:0] cycle_cnt;

   int   n_tests = 0;
   int   n_fail  = 0;
   vec_t vecs[$];

   pc_sequencer #(.D(9), .START_ADDR(0), .CW(CW)) dut (
      .Clk       (Clk),
      .Reset_n   (Reset_n),
      .start     (start),
      .stall     (stall),
      .halt      (halt),
      .target    (target),
      .prog_addr (prog_addr),
      .running   (running),
      .done      (done),
      .cycle_cnt (cycle_cnt)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input int pc, input int run, input int dn, input int cnt);
      chk({tag, " prog_addr"}, int'(prog_addr), pc);
      chk({tag, " running"}, int'(running), run);
      chk({tag, " done"}, int'(done), dn);
      chk({tag, " cycle_cnt"}, int'(cycle_cnt), cnt);
   endtask

   task automatic add(input logic st, input logic sl, input logic hl, input int tg,
                      input int pc, input logic run, input logic dn, input int cnt);
      vec_t v;
      v.start = st; v.stall = sl; v.halt = hl; v.target = 9'(tg);
      v.pc = 9'(pc); v.run = run; v.done = dn; v.cnt = cnt;
      vecs.push_back(v);
   endtask

   initial begin
      int c;
      // idle hold, then start; target modelled as LUT output for the current PC
      add(0, 0, 0, 5,   0, 0, 0, 0);
      add(1, 0, 0, 1,   0, 1, 0, 0);
      add(1, 0, 0, 1,   1, 1, 0, 1);
      add(0, 0, 0, 2,   2, 1, 0, 2);
      add(0, 0, 0, 3,   3, 1, 0, 3);
      add(0, 0, 0, 4,   4, 1, 0, 4);
      add(0, 0, 0, 511, 511, 1, 0, 5);
      add(0, 0, 0, 0,   0, 1, 0, 6);
      c = 6;
      for (int a = 1; a <= 7; a++) begin
         c++;
         add(0, 0, 0, a, a, 1, 0, c);
      end
      for (int k = 0; k < 3; k++) begin
         c++;
         add(0, 1, 0, 8, 7, 1, 0, c);
      end
      for (int a = 8; a <= 20; a++) begin
         c++;
         add(0, 0, 0, a, a, 1, 0, c);
      end
      c++;
      add(0, 1, 1, 21, 20, 0, 1, c);
      add(0, 0, 0, 21, 20, 0, 1, c);
      add(1, 0, 0, 21, 0,  1, 0, 0);
      add(1, 0, 0, 1,  1,  1, 0, 1);

      repeat (2) @(negedge Clk);
      Reset_n = 1'b1;
      @(negedge Clk);
      chk_all("reset", 0, 0, 0, 0);

      foreach (vecs[i]) begin
         start  = vecs[i].start;
         stall  = vecs[i].stall;
         halt   = vecs[i].halt;
         target = vecs[i].target;
         @(negedge Clk);
         chk_all($sformatf("v%0d", i), int'(vecs[i].pc), int'(vecs[i].run),
                 int'(vecs[i].done), vecs[i].cnt);
      end

      // asynchronous reset between edges, mid-RUN
      start  = 1'b0;
      stall  = 1'b0;
      halt   = 1'b0;
      target = 9'd2;
      @(posedge Clk);
      #2 Reset_n = 1'b0;
      #1 chk_all("async_rst", 0, 0, 0, 0);
      @(negedge Clk);
      Reset_n = 1'b1;
      @(negedge Clk);
      chk_all("post_rst_idle", 0, 0, 0, 0);

      // counter saturation at 2**CW-1 while PC keeps advancing
      start = 1'b1;
      @(negedge Clk);
      start = 1'b0;
      chk_all("sat_start", 0, 1, 0, 0);
      for (int k = 0; k < 70; k++) begin
         target = prog_addr + 9'd1;
         @(negedge Clk);
      end
      chk_all("sat", 70, 1, 0, (1 << CW) - 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
